aes_round_sequencer: RTL

Control and buffering block for the iterative AES-128 round datapath. It accepts one encryption request at a time, latches key and plaintext, and drives the core's round controls once per round:

- `first_round_o`
- `final_round_o`
- `round_const_o`
- `round_idx_o`

After a fixed core latency it captures the core's result into an output register and pulses `valid_o`. It replaces the loose round counter and round-constant logic around the AES core with one FSM that owns the request/ready handshake.

---
 rtl/aes_round_sequencer_if.sv | 27 ++
 rtl/aes_round_sequencer.sv | 86 ++++++++
 2 files changed

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: request, round-control and result signals between requester/core and sequencer
interface aes_round_sequencer_if;
    logic         start_i;
    logic [127:0] key_i;
    logic [127:0] data_i;
    logic         ready_o;
    logic         busy_o;
    logic [127:0] core_key_o;
    logic [127:0] core_data_o;
    logic         first_round_o;
    logic         final_round_o;
    logic [7:0]   round_const_o;
    logic [3:0]   round_idx_o;
    logic [127:0] core_out_i;
    logic [127:0] data_o;
    logic         valid_o;
    modport master (
        output start_i, key_i, data_i, core_out_i,
        input  ready_o, busy_o, core_key_o, core_data_o, first_round_o, final_round_o,
               round_const_o, round_idx_o, data_o, valid_o
    );
    modport slave (
        input  start_i, key_i, data_i, core_out_i,
        output ready_o, busy_o, core_key_o, core_data_o, first_round_o, final_round_o,
               round_const_o, round_idx_o, data_o, valid_o
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: per-round control FSM, key/plaintext latch and result capture for an iterative AES-128 core
module aes_round_sequencer #(
    parameter int NUM_ROUNDS   = 10,
    parameter int CORE_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst,
    aes_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
    localparam logic [3:0] LP_NR = 4'(NUM_ROUNDS);
    localparam logic [1:0] LP_CL = 2'(CORE_LATENCY - 1);
    state_t       r_state, w_state_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic [7:0]   r_rcon, w_rcon_nxt;
    logic [1:0]   r_cnt, w_cnt_nxt;
    logic [127:0] r_key, r_data, r_out;
    logic         r_valid;
    logic         w_accept, w_capture;
    // round and Rcon are held at 0 outside RUN so the outputs decode registers only
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_rcon_nxt  = r_rcon;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: if (bus.start_i) begin
                w_accept    = 1'b1;
                w_state_nxt = RUN;
                w_round_nxt = 4'd1;
                w_rcon_nxt  = 8'h01;
            end
            RUN: if (r_round == LP_NR) begin
                w_state_nxt = WAIT;
                w_round_nxt = 4'd0;
                w_rcon_nxt  = 8'h00;
                w_cnt_nxt   = LP_CL;
            end else begin
                w_round_nxt = r_round + 4'd1;
                w_rcon_nxt  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            end
            WAIT: if (r_cnt == 2'd0) begin
                w_capture   = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt = r_cnt - 2'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_round <= '0;
            r_rcon  <= '0;
            r_cnt   <= '0;
            r_key   <= '0;
            r_data  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_rcon  <= w_rcon_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_capture;
            if (w_accept) begin
                r_key  <= bus.key_i;
                r_data <= bus.data_i;
            end
            if (w_capture) r_out <= bus.core_out_i;
        end
    end
    assign bus.ready_o       = r_state == IDLE;
    assign bus.busy_o        = r_state != IDLE;
    assign bus.core_key_o    = r_key;
    assign bus.core_data_o   = r_data;
    assign bus.first_round_o = r_round == 4'd1;
    assign bus.final_round_o = r_round == LP_NR;
    assign bus.round_const_o = r_rcon;
    assign bus.round_idx_o   = r_round;
    assign bus.data_o        = r_out;
    assign bus.valid_o       = r_valid;
endmodule
